mmu_xlate_sched: RTL

- Shared address-translation scheduler between the instruction-fetch and data-memory requesters.
- Arbitrates one translation at a time and resolves kseg0/kseg1 directly.
- Sequences a multi-cycle request/ack lookup on the external TLB for mapped segments (kuseg, kseg2, kseg3).
- Returns paddr, uncached and fault status on a shared response bus with a per-requester done pulse.

---
 rtl/mmu_xlate_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mmu_xlate_sched.sv
// mmu_xlate_sched
//   Shared virtual-to-physical translation scheduler for the instruction-fetch
//   and data-memory requesters. One translation is in flight at a time.
//   kseg0/kseg1 are resolved directly. kuseg/kseg2/kseg3 are looked up in the
//   external TLB through a request/ack handshake. User-mode accesses to the
//   upper half of the address space raise an address error.
//
//   Ports
//     clk, rst                   clock, synchronous active-high reset
//     i_req/i_vaddr/i_user       instruction-side request (held until i_done)
//     d_req/d_vaddr/d_user       data-side request (held until d_done)
//     cp0_kseg0_uncached         kseg0 cacheability (sampled at grant)
//     i_done, d_done             one-cycle completion pulse per requester
//     resp_paddr/_uncached/_fault shared response bus, valid with a done pulse
//     tlb_req/tlb_vpn            TLB lookup request, held until tlb_ack
//     tlb_ack/_hit/_pfn/_uncached TLB result
//
//   Build option
//     MMU_RR_ARB_EN  defined: round-robin between simultaneous requesters,
//                    data side first after reset.
//                    undefined: fixed priority, data always wins.
module mmu_xlate_sched #(
  parameter int VPN_W = 20,
  parameter int PFN_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [31:0]      i_vaddr,
  input  logic             i_user,
  input  logic             d_req,
  input  logic [31:0]      d_vaddr,
  input  logic             d_user,
  input  logic             cp0_kseg0_uncached,
  output logic             i_done,
  output logic             d_done,
  output logic [31:0]      resp_paddr,
  output logic             resp_uncached,
  output logic [1:0]       resp_fault,
  output logic             tlb_req,
  output logic [VPN_W-1:0] tlb_vpn,
  input  logic             tlb_ack,
  input  logic             tlb_hit,
  input  logic [PFN_W-1:0] tlb_pfn,
  input  logic             tlb_uncached
);

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_ADDR = 2'd1;
  localparam logic [1:0] FAULT_MISS = 2'd2;

  state_t            state;
  logic              gnt_d;
  logic [11:0]       off_q;
  logic [31:0]       res_paddr;
  logic              res_uncached;
  logic [1:0]        res_fault;

  logic              any_req;
  logic              sel_d;
  logic [31:0]       sel_vaddr;
  logic              sel_user;
  logic [PFN_W+11:0] tlb_paddr;

  assign any_req = i_req | d_req;

`ifdef MMU_RR_ARB_EN
  // last_d=1 means the data side won the previous grant; cleared by reset so
  // the data side wins the first contested grant.
  logic last_d;

  always_comb sel_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_d <= sel_d;
    end
  end
`else
  always_comb sel_d = d_req;
`endif

  always_comb begin
    sel_vaddr = sel_d ? d_vaddr : i_vaddr;
    sel_user  = sel_d ? d_user  : i_user;
  end

  assign tlb_paddr = {tlb_pfn, off_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      gnt_d         <= 1'b0;
      off_q         <= '0;
      res_paddr     <= '0;
      res_uncached  <= 1'b0;
      res_fault     <= FAULT_NONE;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      resp_paddr    <= '0;
      resp_uncached <= 1'b0;
      resp_fault    <= FAULT_NONE;
      tlb_req       <= 1'b0;
      tlb_vpn       <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_d <= sel_d;
            off_q <= sel_vaddr[11:0];
            if (sel_user && sel_vaddr[31]) begin
              res_paddr    <= '0;
              res_uncached <= 1'b0;
              res_fault    <= FAULT_ADDR;
              state        <= DONE;
            end else if (sel_vaddr[31:29] == 3'b100) begin
              res_paddr    <= {3'b000, sel_vaddr[28:0]};
              res_uncached <= cp0_kseg0_uncached;
              res_fault    <= FAULT_NONE;
              state        <= DONE;
            end else if (sel_vaddr[31:29] == 3'b101) begin
              res_paddr    <= {3'b000, sel_vaddr[28:0]};
              res_uncached <= 1'b1;
              res_fault    <= FAULT_NONE;
              state        <= DONE;
            end else begin
              tlb_req <= 1'b1;
              tlb_vpn <= sel_vaddr[31 -: VPN_W];
              state   <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          // No timeout: the TLB is trusted to answer eventually.
          if (tlb_ack) begin
            tlb_req <= 1'b0;
            if (tlb_hit) begin
              res_paddr    <= 32'(tlb_paddr);
              res_uncached <= tlb_uncached;
              res_fault    <= FAULT_NONE;
            end else begin
              res_paddr    <= '0;
              res_uncached <= 1'b0;
              res_fault    <= FAULT_MISS;
            end
            state <= DONE;
          end
        end
        DONE: begin
          // Response bus is only updated here, so it holds between pulses.
          i_done        <= ~gnt_d;
          d_done        <= gnt_d;
          resp_paddr    <= res_paddr;
          resp_uncached <= res_uncached;
          resp_fault    <= res_fault;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
